// File: rtl/uart_mem_dump.sv
// uart_mem_dump -- serial readback of a data-memory word range over UART 8N1.
//
// Reads word_cnt words starting at base_adr through a synchronous RAM port
// (rd_en/rd_adr, data one cycle later on rd_dat). Each word is sent as four
// little-endian bytes on uart_tx. DIV = CLK_FREQ/BAUD clocks per bit.
//
// Ports:
//   clk       CPU clock, rising edge
//   rst       asynchronous active-low reset
//   start     dump request, sampled in IDLE together with base_adr/word_cnt
//   base_adr  first word address
//   word_cnt  number of words (0 -> immediate done pulse, nothing sent)
//   rd_en     one-cycle read strobe
//   rd_adr    read word address (wraps modulo 2^ADDR_W)
//   rd_dat    read data, valid the cycle after rd_en
//   uart_tx   serial line, idle high, driven from a flop
//   busy      high while a dump is in progress
//   done      one-cycle pulse at completion
//
// Optional feature: define UART_DUMP_CHKSUM_EN to append one byte holding the
// XOR of all data bytes of the dump, sent directly after the last word.

module uart_mem_dump #(
  parameter int CLK_FREQ = 23_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [14:0]       word_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [31:0]       rd_dat,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPT, START, DATA, STOP, CHK, FIN
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_nxt;
  logic [3:0]        bit_idx, bit_nxt;
  logic [1:0]        byte_idx, byte_nxt;
  logic [14:0]       remain, remain_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic              tx_nxt;
  logic [31:0]       sh_word, sh_nxt;
  logic              bit_end;

`ifdef UART_DUMP_CHKSUM_EN
  logic [7:0]        chk, chk_nxt;
`endif

  assign bit_end = (baud_cnt == '0);

  // Next-state and next-output logic. uart_tx is decided here for the
  // coming cycle so the line itself is always a flop output.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_idx;
    byte_nxt   = byte_idx;
    remain_nxt = remain;
    adr_nxt    = rd_adr;
    tx_nxt     = uart_tx;
    sh_nxt     = sh_word;
`ifdef UART_DUMP_CHKSUM_EN
    chk_nxt    = chk;
`endif

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (start) begin
          remain_nxt = word_cnt;
          adr_nxt    = base_adr;
`ifdef UART_DUMP_CHKSUM_EN
          chk_nxt    = 8'h00;
`endif
          // An empty request completes through FIN without touching memory.
          state_nxt  = (word_cnt == 15'd0) ? FIN : FETCH;
        end
      end

      FETCH: state_nxt = CAPT;

      CAPT: begin
        sh_nxt    = rd_dat;
`ifdef UART_DUMP_CHKSUM_EN
        chk_nxt   = chk ^ rd_dat[7:0] ^ rd_dat[15:8] ^ rd_dat[23:16] ^ rd_dat[31:24];
`endif
        byte_nxt  = 2'd0;
        baud_nxt  = BIT_RELOAD;
        tx_nxt    = 1'b0;
        state_nxt = START;
      end

      START: begin
        if (bit_end) begin
          baud_nxt  = BIT_RELOAD;
          bit_nxt   = 4'd0;
          tx_nxt    = sh_word[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt - CNT_W'(1);
        end
      end

      // The word shifts right one bit per data bit, so after eight shifts
      // the next byte of the word sits in [7:0].
      DATA: begin
        if (bit_end) begin
          baud_nxt = BIT_RELOAD;
          sh_nxt   = sh_word >> 1;
          if (bit_idx == 4'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 4'd1;
            tx_nxt  = sh_word[1];
          end
        end else begin
          baud_nxt = baud_cnt - CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_nxt = BIT_RELOAD;
          if (byte_idx != 2'd3) begin
            byte_nxt  = byte_idx + 2'd1;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            remain_nxt = remain - 15'd1;
            adr_nxt    = rd_adr + ADDR_W'(1);
            if (remain == 15'd1) begin
`ifdef UART_DUMP_CHKSUM_EN
              bit_nxt   = 4'd0;
              sh_nxt    = {24'h0, chk};
              tx_nxt    = 1'b0;
              state_nxt = CHK;
`else
              state_nxt = FIN;
`endif
            end else begin
              state_nxt = FETCH;
            end
          end
        end else begin
          baud_nxt = baud_cnt - CNT_W'(1);
        end
      end

`ifdef UART_DUMP_CHKSUM_EN
      // Whole trailer frame in one state: bit_idx 0 = start, 1..8 = data,
      // 9 = stop.
      CHK: begin
        if (bit_end) begin
          baud_nxt = BIT_RELOAD;
          bit_nxt  = bit_idx + 4'd1;
          if (bit_idx == 4'd9) begin
            state_nxt = FIN;
          end else if (bit_idx == 4'd8) begin
            tx_nxt = 1'b1;
          end else if (bit_idx == 4'd0) begin
            tx_nxt = sh_word[0];
          end else begin
            sh_nxt = sh_word >> 1;
            tx_nxt = sh_word[1];
          end
        end else begin
          baud_nxt = baud_cnt - CNT_W'(1);
        end
      end
`endif

      FIN: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      remain   <= '0;
      rd_adr   <= '0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      remain   <= remain_nxt;
      rd_adr   <= adr_nxt;
      rd_en    <= (state_nxt == FETCH);
      busy     <= (state_nxt != IDLE) && (state_nxt != FIN);
      done     <= (state_nxt == FIN);
      uart_tx  <= tx_nxt;
    end
  end

  // Data path: shift word (and checksum) carry no reset; they are always
  // loaded before use.
  always_ff @(posedge clk) begin
    sh_word <= sh_nxt;
`ifdef UART_DUMP_CHKSUM_EN
    chk     <= chk_nxt;
`endif
  end

endmodule
